// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one step per clock, fixed XLEN+2 cycle latency.
module mdu_iterative #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] ALU1,
   input  logic [XLEN-1:0] ALU2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_op;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opb;
   logic [XLEN-1:0]     r_a_raw;
   logic                r_neg;
   logic                r_a_neg;
   logic                r_b_zero;
   logic                r_ovf;
   logic [CW-1:0]       r_cnt;
   logic [XLEN-1:0]     r_result;

   logic                w_a_sgn;
   logic                w_b_sgn;
   logic                w_a_neg;
   logic                w_b_neg;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic [XLEN:0]       w_mul_sum;
   logic [2*XLEN-1:0]   w_mul_next;
   logic [XLEN:0]       w_rem_sh;
   logic                w_ge;
   logic [XLEN-1:0]     w_rem_sub;
   logic [2*XLEN-1:0]   w_div_next;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix;

   // Signedness per op: MULH both, MULHSU A only, DIV/REM both, the rest unsigned.
   assign w_a_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
   assign w_b_sgn = funct3[2] ? ~funct3[0] : (funct3 == 3'b001);
   assign w_a_neg = w_a_sgn & ALU1[XLEN-1];
   assign w_b_neg = w_b_sgn & ALU2[XLEN-1];
   assign w_a_mag = w_a_neg ? -ALU1 : ALU1;
   assign w_b_mag = w_b_neg ? -ALU2 : ALU2;

   // Multiply step: conditionally add the multiplicand to the upper half, shift right.
   assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : '0)};
   assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

   // Divide step: {remainder, quotient} shifts left; the shifted remainder needs XLEN+1 bits.
   assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
   assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
   assign w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opb;
   assign w_div_next = w_ge ? {w_rem_sub, r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0};

   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_quo  = r_acc[XLEN-1:0];
   assign w_rem  = r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix = '0;
      case (r_op)
         3'b000:                 w_fix = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_fix = w_prod[2*XLEN-1:XLEN];
         3'b100: w_fix = r_b_zero ? '1 : r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : (r_neg ? -w_quo : w_quo);
         3'b101: w_fix = r_b_zero ? '1 : w_quo;
         3'b110: w_fix = r_b_zero ? r_a_raw : r_ovf ? '0 : (r_a_neg ? -w_rem : w_rem);
         default: w_fix = r_b_zero ? r_a_raw : w_rem;
      endcase
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_CALC;
         S_CALC: begin
            busy = 1'b1;
            if (r_cnt == CW'(XLEN - 1)) w_next = S_FIX;
         end
         S_FIX: begin
            busy   = 1'b1;
            w_next = S_DONE;
         end
         default: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_a_raw  <= '0;
         r_neg    <= 1'b0;
         r_a_neg  <= 1'b0;
         r_b_zero <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (start) begin
               r_op     <= funct3;
               r_acc    <= {{XLEN{1'b0}}, w_a_mag};
               r_opb    <= w_b_mag;
               r_a_raw  <= ALU1;
               r_neg    <= w_a_neg ^ w_b_neg;
               r_a_neg  <= w_a_neg;
               r_b_zero <= (ALU2 == '0);
               r_ovf    <= (ALU1 == {1'b1, {(XLEN-1){1'b0}}}) && (&ALU2);
               r_cnt    <= '0;
            end
            S_CALC: begin
               r_acc <= r_op[2] ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: r_result <= w_fix;
            default: ;
         endcase
      end
   end

   assign result = r_result;

endmodule
